dmem_port_arbiter: RTL

- Parametrised arbiter that multiplexes NUM_CH requesters onto the single data-cache port of the out-of-order core.
- Typical requesters: load/store buffer reads, ROB store commit, a future prefetcher.
- Replaces the fixed two-source combinational address mux with registered, round-robin arbitration.
- Routes each response back to its owner and discards load responses killed by a pipeline flush.

---
 rtl/dmem_port_arbiter_if.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester-side and cache-side bundle of the dmem arbiter.
// master = arbiter (drives ch_resp/ch_rdata, mem_* strobes); slave = environment.
interface dmem_port_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*BE_W-1:0]   ch_be;
  logic [NUM_CH-1:0]        ch_resp;
  logic [DATA_W-1:0]        ch_rdata;

  logic                     mem_read_d;
  logic                     mem_write_d;
  logic [ADDR_W-1:0]        mem_address_d;
  logic [DATA_W-1:0]        mem_wdata_d;
  logic [BE_W-1:0]          mem_byte_enable_d;
  logic                     mem_resp_d;
  logic [DATA_W-1:0]        mem_rdata_d;

  modport master (
    input  ch_read, ch_write, ch_addr, ch_wdata, ch_be,
    output ch_resp, ch_rdata,
    output mem_read_d, mem_write_d, mem_address_d,
    output mem_wdata_d, mem_byte_enable_d,
    input  mem_resp_d, mem_rdata_d
  );

  modport slave (
    output ch_read, ch_write, ch_addr, ch_wdata, ch_be,
    input  ch_resp, ch_rdata,
    input  mem_read_d, mem_write_d, mem_address_d,
    input  mem_wdata_d, mem_byte_enable_d,
    output mem_resp_d, mem_rdata_d
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin arbiter of NUM_CH requesters onto one dcache port.
// Ports: clk, rst (async active-low), flush, bus (dmem_port_arbiter_if.master).
// One access outstanding at a time; reads killed by flush are swallowed.
// Option: DMEM_ARB_WRITE_PRIO_EN makes pending writes win over reads.
module dmem_port_arbiter #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush,
  dmem_port_arbiter_if.master  bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int CW1  = CH_W + 1;
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   last_grant;
  logic              drop;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [BE_W-1:0]   be_a    [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      addr_a[i]  = bus.ch_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = bus.ch_wdata[i*DATA_W +: DATA_W];
      be_a[i]    = bus.ch_be[i*BE_W +: BE_W];
    end
  end

  // A channel raising read and write together is served as a write.
  logic [NUM_CH-1:0] wr_ok;
  logic [NUM_CH-1:0] rd_ok;
  logic [NUM_CH-1:0] elig;

  assign wr_ok = bus.ch_write;
  assign rd_ok = bus.ch_read & ~bus.ch_write
               & {NUM_CH{~flush}};

`ifdef DMEM_ARB_WRITE_PRIO_EN
  assign elig = (|wr_ok) ? wr_ok : rd_ok;
`else
  assign elig = wr_ok | rd_ok;
`endif

  // Search last_grant+1 .. last_grant (wrapping); walking the
  // distance downwards lets the nearest eligible channel win.
  logic [CH_W-1:0] pick;
  logic            hit;

  always_comb begin : rr_pick
    logic [CH_W:0] j;
    pick = last_grant;
    hit  = 1'b0;
    j    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      j = {1'b0, last_grant} + CW1'(k);
      if (j >= CW1'(NUM_CH))
        j = j - CW1'(NUM_CH);
      if (elig[j[CH_W-1:0]]) begin
        pick = j[CH_W-1:0];
        hit  = 1'b1;
      end
    end
  end

  // A flush landing on the response cycle of a read kills it too.
  logic kill;
  logic done;

  assign kill = drop | (flush & rd_q);
  assign done = (state == BUSY) & bus.mem_resp_d;

  assign bus.ch_resp  = (done & ~kill)
                      ? (NUM_CH'(1) << grant)
                      : '0;
  assign bus.ch_rdata = bus.mem_rdata_d;

  assign bus.mem_read_d        = rd_q;
  assign bus.mem_write_d       = wr_q;
  assign bus.mem_address_d     = addr_q;
  assign bus.mem_wdata_d       = wdata_q;
  assign bus.mem_byte_enable_d = be_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      drop       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            grant      <= pick;
            last_grant <= pick;
            wr_q       <= wr_ok[pick];
            rd_q       <= ~wr_ok[pick];
            addr_q     <= addr_a[pick];
            wdata_q    <= wdata_a[pick];
            be_q       <= be_a[pick];
            drop       <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp_d) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            drop    <= 1'b0;
            state   <= IDLE;
          end else if (flush && rd_q) begin
            drop <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
